// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception arbiter, flush sequencer and CP0 interrupt conditioning.
// Optional feature macro: EXC_INT_SYNC_EN (2-flop synchronizer on int_i).
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [4:0]  exc_flags_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [5:0]  cp0_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] npc_q, npc_nxt;

    logic [31:0] status_fwd;
    logic [31:0] epc_fwd;
    logic [7:0]  cause_ip;
    logic        int_pending;
    logic        detect;
    logic        unused;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_s1, int_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_s1 <= '0;
            int_s2 <= '0;
        end else begin
            int_s1 <= int_i;
            int_s2 <= int_s1;
        end
    end

    assign cp0_int_o = int_s2 | {timer_int_i, 5'b0};
`else
    assign cp0_int_o = int_i | {timer_int_i, 5'b0};
`endif

    // Only the interrupt-pending bits of Cause matter here; of those, IP[1:0] are software-writable.
    assign status_fwd = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
    assign epc_fwd    = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
    assign cause_ip   = {cp0_cause_i[15:10],
                         (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8]};

    assign int_pending = status_fwd[0] && !status_fwd[1] && ((cause_ip & status_fwd[15:8]) != 8'd0);
    assign detect      = (state == IDLE) && valid_i && (int_pending || (exc_flags_i != 5'd0));

    assign unused = ^{cp0_cause_i[31:16], cp0_cause_i[7:0], status_fwd[31:16], status_fwd[7:2]};

    assign current_inst_addr_o = pc_i;
    assign is_in_delayslot_o   = in_delayslot_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            npc_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            npc_q <= npc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        npc_nxt      = npc_q;
        excepttype_o = 32'h0;
        flush_o      = 1'b0;
        new_pc_o     = 32'h0;
        busy_o       = 1'b0;

        case (state)
            IDLE: begin
                if (detect) begin
                    if (int_pending)         excepttype_o = 32'h1;
                    else if (exc_flags_i[0]) excepttype_o = 32'h8;
                    else if (exc_flags_i[1]) excepttype_o = 32'ha;
                    else if (exc_flags_i[2]) excepttype_o = 32'hd;
                    else if (exc_flags_i[3]) excepttype_o = 32'hc;
                    else                     excepttype_o = 32'he;

                    flush_o  = 1'b1;
                    new_pc_o = (excepttype_o == 32'he) ? epc_fwd : EXC_VECTOR;
                    npc_nxt  = new_pc_o;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            FLUSH: begin
                flush_o  = 1'b1;
                new_pc_o = npc_q;
                busy_o   = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl (FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances).
module tb_exc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, delayslot, timer_int, wb_we;
    logic [31:0] pc, status, cause, epc, wb_data;
    logic [4:0]  flags, wb_waddr;
    logic [5:0]  int_in;

    logic [31:0] exc_1, cia_1, npc_1, exc_3, cia_3, npc_3;
    logic        ds_1, flush_1, busy_1, ds_3, flush_3, busy_3;
    logic [5:0]  cpint_1, cpint_3;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef EXC_INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc), .in_delayslot_i(delayslot),
        .exc_flags_i(flags), .int_i(int_in), .timer_int_i(timer_int),
        .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(exc_1), .current_inst_addr_o(cia_1), .is_in_delayslot_o(ds_1),
        .cp0_int_o(cpint_1), .flush_o(flush_1), .new_pc_o(npc_1), .busy_o(busy_1));

    exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc), .in_delayslot_i(delayslot),
        .exc_flags_i(flags), .int_i(int_in), .timer_int_i(timer_int),
        .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(exc_3), .current_inst_addr_o(cia_3), .is_in_delayslot_o(ds_3),
        .cp0_int_o(cpint_3), .flush_o(flush_3), .new_pc_o(npc_3), .busy_o(busy_3));

    // Reference: architectural view of which exception the MEM instruction raises.
    function automatic logic [31:0] ref_exc(input logic v, input logic [4:0] f, input logic [31:0] st_in,
                                            input logic [31:0] ca_in, input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        logic [31:0] st, ca;
        logic [31:0] codes [5];
        logic        pend;
        st = (we && wa == 5'd12) ? wd : st_in;
        ca = ca_in;
        if (we && wa == 5'd13) begin
            ca[9:8] = wd[9:8];
            ca[22]  = wd[22];
            ca[23]  = wd[23];
        end
        pend = (st[0] == 1'b1) && (st[1] == 1'b0) && (((ca >> 8) & (st >> 8) & 32'hff) != 0);
        codes[0] = 32'h8; codes[1] = 32'ha; codes[2] = 32'hd; codes[3] = 32'hc; codes[4] = 32'he;
        if (!v) return 32'h0;
        if (pend) return 32'h1;
        for (int i = 0; i < 5; i++) if (f[i]) return codes[i];
        return 32'h0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        valid = 0; pc = 0; delayslot = 0; flags = 0; int_in = 0; timer_int = 0;
        status = 0; cause = 0; epc = 0; wb_we = 0; wb_waddr = 0; wb_data = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        tick(); tick();
        @(negedge clk);
        n_cmp++; if ({exc_1, npc_1, flush_1, busy_1} !== 66'h0) begin n_bad++;
            $display("FAIL reset_dut1 got exc=%h npc=%h flush=%b busy=%b want all 0", exc_1, npc_1, flush_1, busy_1); end
        n_cmp++; if ({exc_3, npc_3, flush_3, busy_3} !== 66'h0) begin n_bad++;
            $display("FAIL reset_dut3 got exc=%h npc=%h flush=%b busy=%b want all 0", exc_3, npc_3, flush_3, busy_3); end
        n_cmp++; if (cpint_1 !== 6'h0) begin n_bad++;
            $display("FAIL reset_cp0_int got %h want 0", cpint_1); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_syscall;
        clear_inputs();
        valid = 1; pc = 32'h100; flags = 5'b00001; delayslot = 1;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h8) begin n_bad++; $display("FAIL syscall_exc got %h want 8", exc_1); end
        n_cmp++; if (flush_1 !== 1'b1) begin n_bad++; $display("FAIL syscall_flush got %b want 1", flush_1); end
        n_cmp++; if (npc_1 !== 32'h20) begin n_bad++; $display("FAIL syscall_newpc got %h want 20", npc_1); end
        n_cmp++; if (cia_1 !== 32'h100 || ds_1 !== 1'b1) begin n_bad++;
            $display("FAIL syscall_addr got %h/%b want 100/1", cia_1, ds_1); end
        tick();
        flags = 5'b01001;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h8) begin n_bad++; $display("FAIL syscall_ovf_prio got %h want 8", exc_1); end
        tick();
        flags = 5'b01001; valid = 0;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h0 || flush_1 !== 1'b0) begin n_bad++;
            $display("FAIL bubble got exc=%h flush=%b want 0/0", exc_1, flush_1); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_interrupt_wins;
        clear_inputs();
        valid = 1; pc = 32'h200; flags = 5'b00001; status = 32'h0000_0401; cause = 32'h0000_0400;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h1) begin n_bad++; $display("FAIL int_wins got %h want 1", exc_1); end
        tick();
        status = 32'h0000_0403;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h8) begin n_bad++; $display("FAIL int_exl_masked got %h want 8", exc_1); end
        tick();
        status = 32'h0; cause = 32'h0; flags = 0;
        wb_we = 1; wb_waddr = 5'd12; wb_data = 32'h0000_0401; cause = 32'h0000_0400;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'h1) begin n_bad++; $display("FAIL int_status_fwd got %h want 1", exc_1); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_eret_fwd;
        clear_inputs();
        valid = 1; pc = 32'h300; flags = 5'b10000; epc = 32'h40;
        wb_we = 1; wb_waddr = 5'd14; wb_data = 32'h80;
        @(negedge clk);
        n_cmp++; if (exc_1 !== 32'he) begin n_bad++; $display("FAIL eret_exc got %h want e", exc_1); end
        n_cmp++; if (npc_1 !== 32'h80) begin n_bad++; $display("FAIL eret_fwd_pc got %h want 80", npc_1); end
        tick();
        wb_we = 0;
        @(negedge clk);
        n_cmp++; if (npc_1 !== 32'h40) begin n_bad++; $display("FAIL eret_pc got %h want 40", npc_1); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random;
        logic [31:0] want;
        logic [1:0]  sel;
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            valid     = ($urandom_range(0, 7) != 0);
            pc        = $urandom;
            delayslot = 1'($urandom_range(0, 1));
            flags     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            status    = $urandom;
            status[1:0] = 2'($urandom_range(0, 3));
            cause     = $urandom;
            epc       = $urandom;
            wb_we     = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            wb_waddr  = (sel == 2'd3) ? 5'($urandom) : 5'd12 + 5'(sel);
            wb_data   = $urandom;
            wb_data[1:0] = 2'($urandom_range(0, 3));
            want = ref_exc(valid, flags, status, cause, wb_we, wb_waddr, wb_data);
            @(negedge clk);
            n_cmp++; if (exc_1 !== want || flush_1 !== (want != 0) || busy_1 !== 1'b0) begin n_bad++;
                $display("FAIL rand_exc[%0d] got exc=%h flush=%b busy=%b want exc=%h flush=%b busy=0",
                         i, exc_1, flush_1, busy_1, want, want != 0); end
            if (want != 0) begin
                n_cmp++;
                if (npc_1 !== ((want == 32'he) ? ((wb_we && wb_waddr == 5'd14) ? wb_data : epc) : 32'h20)) begin
                    n_bad++; $display("FAIL rand_newpc[%0d] got %h exc=%h", i, npc_1, want); end
            end
            n_cmp++; if (cia_1 !== pc || ds_1 !== delayslot) begin n_bad++;
                $display("FAIL rand_mirror[%0d] got %h/%b want %h/%b", i, cia_1, ds_1, pc, delayslot); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        clear_inputs();
        valid = 1; pc = 32'h400; flags = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (exc_1 !== 32'hd || flush_1 !== 1'b1) begin n_bad++;
                $display("FAIL b2b[%0d] got exc=%h flush=%b want d/1", i, exc_1, flush_1); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_flush3;
        int nf, nb;
        rst = 1; clear_inputs(); tick(); rst = 0; tick();
        nf = 0; nb = 0;
        valid = 1; pc = 32'h500; flags = 5'b00100;
        @(negedge clk);
        n_cmp++; if (exc_3 !== 32'hd || npc_3 !== 32'h20) begin n_bad++;
            $display("FAIL flush3_detect got exc=%h npc=%h want d/20", exc_3, npc_3); end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (flush_3) nf++;
            if (busy_3) nb++;
            if (c == 1) begin
                n_cmp++; if (exc_3 !== 32'h0 || npc_3 !== 32'h20) begin n_bad++;
                    $display("FAIL flush3_ignore got exc=%h npc=%h want 0/20", exc_3, npc_3); end
            end
            tick();
            flags = (c == 0) ? 5'b00001 : 5'd0;
            valid = (c == 0);
        end
        n_cmp++; if (nf != 3) begin n_bad++; $display("FAIL flush3_len got %0d want 3", nf); end
        n_cmp++; if (nb != 2) begin n_bad++; $display("FAIL flush3_busy got %0d want 2", nb); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_flush;
        clear_inputs();
        valid = 1; flags = 5'b01000;
        tick();
        clear_inputs();
        tick();
        rst = 1;
        @(negedge clk);
        n_cmp++; if (busy_3 !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got busy=%b want 1", busy_3); end
        tick();
        rst = 0;
        @(negedge clk);
        n_cmp++; if (flush_3 !== 1'b0 || busy_3 !== 1'b0) begin n_bad++;
            $display("FAIL midrst got flush=%b busy=%b want 0/0", flush_3, busy_3); end
        tick();
    endtask

    task automatic test_cp0_int;
        clear_inputs();
        tick(); tick(); tick();
        int_in = 6'h01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (cpint_1 !== ((k >= SYNC_LAT) ? 6'h01 : 6'h00)) begin n_bad++;
                $display("FAIL cp0_int[%0d] got %h want %h", k, cpint_1, (k >= SYNC_LAT) ? 6'h01 : 6'h00); end
            tick();
        end
        int_in = 6'h00; timer_int = 1;
        @(negedge clk);
        n_cmp++; if (cpint_1[5] !== 1'b1) begin n_bad++; $display("FAIL timer_int got %b want 1", cpint_1[5]); end
        tick();
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_syscall();
        test_interrupt_wins();
        test_eret_fwd();
        test_random();
        test_back_to_back();
        test_flush3();
        test_reset_mid_flush();
        test_cp0_int();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
